// File: rtl/uart_pkg.sv
// uart_pkg: types and constants shared by the UART transmitter and receiver.
//   uart_state_t          - frame FSM states, used by both directions
//   CLKS_PER_BIT_DEFAULT  - 50 MHz / 115200 baud, truncated
//   DATA_W                - bits per character
//   BAUD_CNT_W            - width of the bit-period counter (covers 2..65535)
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START_BIT = 2'd1,
    DATA_BITS = 2'd2,
    STOP_BIT  = 2'd3
  } uart_state_t;

  localparam int CLKS_PER_BIT_DEFAULT = 434;
  localparam int DATA_W               = 8;
  localparam int BAUD_CNT_W           = 16;

endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: bit-period counter, counts 0..CLKS_PER_BIT-1 and wraps.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-low reset
//   en   - advance the count this cycle
//   clr  - force the count back to 0 (has priority over en)
//   tc   - terminal count: high in the last cycle of a bit period while enabled
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tc
);

  localparam logic [BAUD_CNT_W-1:0] TC_VAL = BAUD_CNT_W'(CLKS_PER_BIT - 1);

  logic [BAUD_CNT_W-1:0] cnt;

  assign tc = en && (cnt == TC_VAL);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == TC_VAL) ? '0 : cnt + BAUD_CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter with valid/ready byte input.
// Ports:
//   clk          - system clock, rising edge
//   rst          - asynchronous active-low reset
//   tx_data      - byte to send, captured only when accepted
//   tx_valid     - requester has a byte on tx_data
//   tx_ready     - a byte can be accepted this cycle (IDLE only)
//   UART_tx      - registered serial line, idle high, LSB first
//   tx_done      - one-cycle pulse in the first IDLE cycle after the stop bit
//   Tx_state_out - current FSM state
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              UART_tx,
  output logic              tx_done,
  output uart_state_t       Tx_state_out
);

  uart_state_t       state, state_next;
  logic [DATA_W-1:0] shreg, shreg_next;
  logic [2:0]        idx, idx_next;
  logic              line_next;
  logic              done_next;
  logic              tc;
  logic              accept;

  assign accept       = tx_valid && tx_ready;
  assign Tx_state_out = state;

  // Counter is held at 0 in IDLE so the start bit always gets a full period.
  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_cnt (
    .clk(clk),
    .rst(rst),
    .en (state != IDLE),
    .clr(state == IDLE),
    .tc (tc)
  );

  // The line is registered from line_next, so each branch sets the value the
  // line must carry in the state being entered. The shift register's LSB is
  // always the data bit currently on the line.
  always_comb begin
    state_next = state;
    shreg_next = shreg;
    idx_next   = idx;
    line_next  = 1'b1;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = START_BIT;
          shreg_next = tx_data;
          idx_next   = 3'd0;
          line_next  = 1'b0;
        end
      end
      START_BIT: begin
        line_next = 1'b0;
        if (tc) begin
          state_next = DATA_BITS;
          line_next  = shreg[0];
        end
      end
      DATA_BITS: begin
        line_next = shreg[0];
        if (tc) begin
          if (idx == 3'd7) begin
            state_next = STOP_BIT;
            line_next  = 1'b1;
          end else begin
            shreg_next = shreg >> 1;
            idx_next   = idx + 3'd1;
            line_next  = shreg[1];
          end
        end
      end
      STOP_BIT: begin
        if (tc) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // tx_ready is registered from the next state: it stays low during reset and
  // rises on the first edge after release, and on the edge returning to IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      shreg    <= '0;
      idx      <= '0;
      UART_tx  <= 1'b1;
      tx_done  <= 1'b0;
      tx_ready <= 1'b0;
    end else begin
      state    <= state_next;
      shreg    <= shreg_next;
      idx      <= idx_next;
      UART_tx  <= line_next;
      tx_done  <= done_next;
      tx_ready <= (state_next == IDLE);
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx at CLKS_PER_BIT=4.
// A frame-timeline model (cycles since acceptance) predicts line, ready,
// done and state every cycle; directed scenarios add literal expectations.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        UART_tx;
  logic        tx_done;
  uart_state_t Tx_state_out;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk),
    .rst(rst),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .UART_tx(UART_tx),
    .tx_done(tx_done),
    .Tx_state_out(Tx_state_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Model: m_t = cycles since the accepting edge (-1 when idle).
  int         m_t    = -1;
  logic [7:0] m_fb   = 8'h00;
  logic       m_rdy  = 1'b0;
  logic       m_done = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_t    <= -1;
      m_rdy  <= 1'b0;
      m_done <= 1'b0;
    end else if (m_t < 0) begin
      m_done <= 1'b0;
      if (m_rdy && tx_valid) begin
        m_fb  <= tx_data;
        m_t   <= 0;
        m_rdy <= 1'b0;
      end else begin
        m_rdy <= 1'b1;
      end
    end else if (m_t == FRAME - 1) begin
      m_t    <= -1;
      m_rdy  <= 1'b1;
      m_done <= 1'b1;
    end else begin
      m_t    <= m_t + 1;
      m_done <= 1'b0;
    end
  end

  function automatic logic exp_line();
    int b;
    if (m_t < 0) return 1'b1;
    b = m_t / CPB;
    if (b == 0) return 1'b0;
    if (b <= 8) return m_fb[b-1];
    return 1'b1;
  endfunction

  function automatic uart_state_t exp_state();
    int b;
    if (m_t < 0) return IDLE;
    b = m_t / CPB;
    if (b == 0) return START_BIT;
    if (b <= 8) return DATA_BITS;
    return STOP_BIT;
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_line", UART_tx, exp_line());
      chk("model_ready", tx_ready, m_rdy);
      chk("model_done", tx_done, m_done);
      chk("model_state", Tx_state_out, exp_state());
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (tx_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk("ready_timeout", 0, 1);
  endtask

  // Returns one sample after the accepting edge (sample index 0).
  task automatic send_start(input logic [7:0] d);
    wait_ready();
    tx_valid = 1'b1;
    tx_data  = d;
    tick();
    tx_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic       seq [10];
    logic [7:0] bits;
    int         pulses, first, done_k, start2_k, rdy_cnt;

    seq = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    // Reset
    rst      = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    cmp_en = 1'b1;
    chk("rst_line", UART_tx, 1);
    chk("rst_ready", tx_ready, 0);
    chk("rst_state", Tx_state_out, IDLE);
    rst = 1'b1;
    tick();
    chk("rst_release_ready", tx_ready, 1);

    // Single frame 8'hA5
    send_start(8'hA5);
    pulses = 0;
    first  = -1;
    for (int k = 0; k < FRAME + 6; k++) begin
      if (k < FRAME) chk("a5_line", UART_tx, seq[k/CPB]);
      if (tx_done) begin
        pulses++;
        if (first < 0) first = k;
      end
      tx_data = 8'($urandom);
      tick();
    end
    chk("a5_done_cycle", first, 40);
    chk("a5_done_pulses", pulses, 1);

    // Back-to-back with tx_valid held
    wait_ready();
    tx_valid = 1'b1;
    tx_data  = 8'h00;
    tick();
    tx_data  = 8'hFF;
    done_k   = -1;
    start2_k = -1;
    rdy_cnt  = 0;
    for (int k = 0; k < 90; k++) begin
      if (tx_done && done_k < 0) done_k = k;
      if (start2_k < 0 && tx_ready) rdy_cnt++;
      if (done_k >= 0 && start2_k < 0 && Tx_state_out == START_BIT) begin
        start2_k = k;
        tx_valid = 1'b0;
      end
      tick();
    end
    chk("b2b_done_cycle", done_k, 40);
    chk("b2b_start2_cycle", start2_k, 41);
    chk("b2b_ready_cycles", rdy_cnt, 1);

    // Data hold: tx_data changes mid-frame
    send_start(8'h81);
    bits = 8'h00;
    for (int k = 0; k < FRAME + 4; k++) begin
      if (k == 10) tx_data = 8'h3C;
      if (k % CPB == 2 && k / CPB >= 1 && k / CPB <= 8) bits[k/CPB-1] = UART_tx;
      tick();
    end
    chk("hold_byte", bits, 8'h81);

    // Mid-frame reset during data bit 3
    send_start(8'h00);
    repeat (17) tick();
    chk("mr_line_before", UART_tx, 0);
    rst = 1'b0;
    #1;
    chk("mr_line_async", UART_tx, 1);
    chk("mr_ready", tx_ready, 0);
    chk("mr_state", Tx_state_out, IDLE);
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      if (tx_done) pulses++;
      tick();
    end
    rst = 1'b1;
    for (int k = 0; k < FRAME + 5; k++) begin
      if (tx_done) pulses++;
      tick();
    end
    chk("mr_no_done", pulses, 0);
    send_start(8'h55);
    bits = 8'h00;
    for (int k = 0; k < FRAME + 4; k++) begin
      if (k % CPB == 2 && k / CPB >= 1 && k / CPB <= 8) bits[k/CPB-1] = UART_tx;
      tick();
    end
    chk("mr_next_byte", bits, 8'h55);

    // Random traffic, including a reset in the middle
    for (int i = 0; i < 3000; i++) begin
      tx_valid = ($urandom_range(0, 7) == 0);
      tx_data  = 8'($urandom);
      if (i == 1777) rst = 1'b0;
      if (i == 1780) rst = 1'b1;
      tick();
    end
    tx_valid = 1'b0;
    repeat (FRAME + 5) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
